// File: rtl/core_mem_host.sv
// core_mem_host: register-file memory shared by the accumulator core and a host.
//
// The core reads instructions and operands combinationally and pushes
// accumulator values back while in RUN. Outside RUN the host owns the RAM: it
// can stream a full program in (LOAD) or stream the whole memory out (DUMP).
// The core is held in reset whenever the host owns memory.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   core_reset                  registered reset to the core, low only in RUN
//   core_pc_addr/core_pc_data   instruction fetch port (async read)
//   core_op_addr/core_op_data   operand port (async read), also push address
//   core_write/core_wdata       push strobe and data from the core
//   load_req/dump_req/run_req   host commands, sampled in IDLE
//   halt_req                    host command, sampled in RUN
//   in_data/in_valid/in_ready   host load stream
//   out_data/out_valid/out_ready host dump stream
//   done                        one-cycle pulse after the last LOAD/DUMP word
//   busy                        high whenever not IDLE
module core_mem_host #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned DEPTH      = WORD_WIDTH,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  core_reset,
  input  logic [AW-1:0]         core_pc_addr,
  output logic [WORD_WIDTH-1:0] core_pc_data,
  input  logic [AW-1:0]         core_op_addr,
  output logic [WORD_WIDTH-1:0] core_op_data,
  input  logic                  core_write,
  input  logic [WORD_WIDTH-1:0] core_wdata,
  input  logic                  load_req,
  input  logic                  dump_req,
  input  logic                  run_req,
  input  logic                  halt_req,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned AW1 = AW + 1;
  localparam logic [AW:0]   DepthW  = AW1'(DEPTH);
  localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDump, StRun} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic                  done_q, done_d;
  logic                  core_reset_q;
  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic                  pc_in_range, op_in_range;

  // Non-power-of-two depths leave holes in the address space: they read 0 and
  // swallow writes.
  assign pc_in_range = {1'b0, core_pc_addr} < DepthW;
  assign op_in_range = {1'b0, core_op_addr} < DepthW;

  assign core_pc_data = pc_in_range ? mem_q[core_pc_addr] : '0;
  assign core_op_data = op_in_range ? mem_q[core_op_addr] : '0;

  // ptr only moves on a handshake and nothing writes memory in DUMP, so
  // out_data is naturally stable while the host stalls.
  assign out_data   = out_valid ? mem_q[ptr_q] : '0;
  assign done       = done_q;
  assign busy       = (state_q != StIdle);
  assign core_reset = core_reset_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = in_data;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_req) begin
          state_d = StLoad;
          ptr_d   = '0;
        end else if (dump_req) begin
          state_d = StDump;
          ptr_d   = '0;
        end else if (run_req) begin
          state_d = StRun;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we = 1'b1;
          if (ptr_q == LastPtr) begin
            ptr_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      StDump: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (ptr_q == LastPtr) begin
            ptr_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      StRun: begin
        // A push coinciding with halt_req still lands.
        if (core_write && op_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = core_op_addr;
          mem_wdata = core_wdata;
        end
        if (halt_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      done_q       <= 1'b0;
      core_reset_q <= 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      done_q       <= done_d;
      core_reset_q <= (state_d != StRun);
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_core_mem_host.sv
module tb_core_mem_host;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_reset;
  logic [AW-1:0] core_pc_addr, core_op_addr;
  logic [W-1:0]  core_pc_data, core_op_data, core_wdata;
  logic          core_write;
  logic          load_req, dump_req, run_req, halt_req;
  logic [W-1:0]  in_data, out_data;
  logic          in_valid, in_ready, out_valid, out_ready, done, busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference memory image and the program used by the next load.
  logic [W-1:0] model_mem [D];
  logic [W-1:0] prog [D];

  always #5 clk = ~clk;

  core_mem_host #(.WORD_WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .core_reset  (core_reset),
    .core_pc_addr(core_pc_addr),
    .core_pc_data(core_pc_data),
    .core_op_addr(core_op_addr),
    .core_op_data(core_op_data),
    .core_write  (core_write),
    .core_wdata  (core_wdata),
    .load_req    (load_req),
    .dump_req    (dump_req),
    .run_req     (run_req),
    .halt_req    (halt_req),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .done        (done),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < D; i++) model_mem[i] = '0;
    tests_run++;
    if (core_reset !== 1'b1) begin
      tests_failed++; $display("FAIL reset_core_reset: got %b expected 1", core_reset);
    end
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got busy=%b in_ready=%b out_valid=%b done=%b expected 0000",
               busy, in_ready, out_valid, done);
    end
    for (int a = 0; a < D; a++) begin
      core_pc_addr = AW'(a);
      #1;
      tests_run++;
      if (core_pc_data !== 8'h00) begin
        tests_failed++; $display("FAIL reset_mem[%0d]: got %h expected 00", a, core_pc_data);
      end
    end
  endtask

  // Streams prog[] into memory, optionally with random idle gaps, and verifies
  // handshake timing, the done pulse and the resulting memory image.
  task automatic load_program(input bit with_dump, input bit random_gaps);
    int gaps;
    load_req = 1'b1;
    dump_req = with_dump;
    tick();
    load_req = 1'b0;
    dump_req = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_enter: got in_ready=%b out_valid=%b busy=%b expected 101",
               in_ready, out_valid, busy);
    end
    for (int i = 0; i < D; i++) begin
      in_data  = prog[i];
      in_valid = 1'b1;
      tests_run++;
      if (in_ready !== 1'b1 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL load_word%0d: got in_ready=%b done=%b expected 1 0", i, in_ready, done);
      end
      tick();
      in_valid     = 1'b0;
      model_mem[i] = prog[i];
      if (i < D - 1) begin
        gaps = random_gaps ? 1 + int'($urandom_range(0, 2)) : 1;
        for (int g = 0; g < gaps; g++) begin
          in_data = W'($urandom);
          tick();
        end
      end
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_done: got done=%b busy=%b in_ready=%b expected 100",
               done, busy, in_ready);
    end
    tick();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++; $display("FAIL load_done_pulse: got %b expected 0", done);
    end
    for (int a = 0; a < D; a++) begin
      core_pc_addr = AW'(a);
      #1;
      tests_run++;
      if (core_pc_data !== model_mem[a]) begin
        tests_failed++;
        $display("FAIL load_mem[%0d]: got %h expected %h", a, core_pc_data, model_mem[a]);
      end
    end
  endtask

  task automatic test_load();
    logic [W-1:0] fixed [D];
    fixed = '{8'h21, 8'h05, 8'h40, 8'h81, 8'h00, 8'h00, 8'h00, 8'h03};
    for (int i = 0; i < D; i++) prog[i] = fixed[i];
    load_program(1'b0, 1'b0);
  endtask

  task automatic test_dump(input int stall_word, input int stall_len, input bit rand_ready);
    int idx = 0;
    int stalled = 0;
    int cycles = 0;
    logic r;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    while (idx < D && cycles < 200) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== model_mem[idx] || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL dump_word%0d: got valid=%b data=%h in_ready=%b expected 1 %h 0",
                 idx, out_valid, out_data, in_ready, model_mem[idx]);
      end
      if (idx == stall_word && stalled < stall_len) begin
        r = 1'b0;
        stalled++;
      end else begin
        r = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      out_ready = r;
      tick();
      cycles++;
      if (r) begin
        idx++;
        if (idx < D) begin
          tests_run++;
          if (done !== 1'b0) begin
            tests_failed++; $display("FAIL dump_early_done: got %b expected 0", done);
          end
        end
      end
    end
    out_ready = 1'b0;
    tests_run++;
    if (idx != D) begin
      tests_failed++; $display("FAIL dump_timeout: got %0d words expected %0d", idx, D);
    end
    tests_run++;
    if (done !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL dump_done: got done=%b valid=%b data=%h busy=%b expected 1 0 00 0",
               done, out_valid, out_data, busy);
    end
    tick();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++; $display("FAIL dump_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_run();
    logic [W-1:0]  d;
    logic [AW-1:0] a;
    run_req = 1'b1;
    tests_run++;
    if (core_reset !== 1'b1) begin
      tests_failed++; $display("FAIL run_pre_core_reset: got %b expected 1", core_reset);
    end
    tick();
    run_req = 1'b0;
    tests_run++;
    if (core_reset !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL run_enter: got core_reset=%b busy=%b expected 0 1", core_reset, busy);
    end
    core_write   = 1'b1;
    core_op_addr = 3'd5;
    core_wdata   = 8'hA7;
    tick();
    core_write   = 1'b0;
    model_mem[5] = 8'hA7;
    tests_run++;
    if (core_op_data !== 8'hA7) begin
      tests_failed++; $display("FAIL run_push: got %h expected a7", core_op_data);
    end
    for (int k = 0; k < 4; k++) begin
      a = AW'($urandom_range(0, D - 1));
      d = W'($urandom);
      core_op_addr = a;
      core_wdata   = d;
      core_write   = 1'b1;
      tick();
      core_write   = 1'b0;
      model_mem[a] = d;
    end
    for (int i = 0; i < D; i++) begin
      core_pc_addr = AW'(i);
      #1;
      tests_run++;
      if (core_pc_data !== model_mem[i]) begin
        tests_failed++;
        $display("FAIL run_mem[%0d]: got %h expected %h", i, core_pc_data, model_mem[i]);
      end
    end
    // Halt with a coincident push to address 3.
    d = W'($urandom);
    halt_req     = 1'b1;
    core_write   = 1'b1;
    core_op_addr = 3'd3;
    core_wdata   = d;
    tick();
    halt_req     = 1'b0;
    core_write   = 1'b0;
    model_mem[3] = d;
    tests_run++;
    if (core_reset !== 1'b1 || busy !== 1'b0 || core_op_data !== d) begin
      tests_failed++;
      $display("FAIL run_halt: got core_reset=%b busy=%b mem3=%h expected 1 0 %h",
               core_reset, busy, core_op_data, d);
    end
    // Pushes in IDLE are dropped; halt_req in IDLE does nothing.
    core_write   = 1'b1;
    core_op_addr = 3'd5;
    core_wdata   = 8'h11;
    halt_req     = 1'b1;
    tick();
    core_write   = 1'b0;
    halt_req     = 1'b0;
    tests_run++;
    if (core_op_data !== model_mem[5] || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_push: got mem5=%h busy=%b expected %h 0",
               core_op_data, busy, model_mem[5]);
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < D; i++) prog[i] = W'($urandom);
    load_program(1'b1, 1'b1);
  endtask

  task automatic test_reset_midload();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data  = W'($urandom) | 8'h01;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    for (int i = 0; i < D; i++) model_mem[i] = '0;
    tests_run++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || core_reset !== 1'b1) begin
      tests_failed++;
      $display("FAIL midload_reset: got in_ready=%b busy=%b done=%b core_reset=%b expected 0001",
               in_ready, busy, done, core_reset);
    end
    for (int a = 0; a < D; a++) begin
      core_pc_addr = AW'(a);
      #1;
      tests_run++;
      if (core_pc_data !== 8'h00) begin
        tests_failed++; $display("FAIL midload_mem[%0d]: got %h expected 00", a, core_pc_data);
      end
    end
    for (int i = 0; i < D; i++) prog[i] = W'($urandom);
    load_program(1'b0, 1'b1);
  endtask

  initial begin
    reset        = 1'b1;
    core_pc_addr = '0;
    core_op_addr = '0;
    core_write   = 1'b0;
    core_wdata   = '0;
    load_req     = 1'b0;
    dump_req     = 1'b0;
    run_req      = 1'b0;
    halt_req     = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    test_reset();
    test_load();
    test_dump(2, 3, 1'b0);
    test_run();
    test_dump(-1, 0, 1'b1);
    test_priority();
    test_dump($urandom_range(0, D - 1), 2, 1'b1);
    test_reset_midload();
    test_dump(-1, 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
